cv32e40px_x_result_wb_buffer: RTL

//  Buffers eXtension-interface (CORE-V-XIF) result writebacks and drives register-file write port B.

---
 rtl/cv32e40px_x_result_wb_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cv32e40px_x_result_wb_buffer.sv
// rtl/cv32e40px_x_result_wb_buffer.sv - x-result writeback FIFO driving regfile write port B
// Optional read-hazard flags are enabled with CV32E40PX_XWB_HAZARD_EN.
module cv32e40px_x_result_wb_buffer #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned X_DUALWRITE = 0,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 x_result_valid_i,
  output logic                                 x_result_ready_o,
  input  logic [ADDR_WIDTH-1:0]                x_result_rd_i,
  input  logic [X_DUALWRITE:0][DATA_WIDTH-1:0] x_result_data_i,
  input  logic [X_DUALWRITE:0]                 x_result_we_i,
  input  logic                                 core_we_b_i,
  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [X_DUALWRITE:0][DATA_WIDTH-1:0] wdata_b_o,
  output logic [X_DUALWRITE:0]                 we_b_o,
  output logic                                 empty_o,
  output logic                                 misalign_err_o
`ifdef CV32E40PX_XWB_HAZARD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]                raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]                raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]                raddr_c_i,
  output logic [2:0]                           hazard_o
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned N     = X_DUALWRITE + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0]                mem_rd_q   [DEPTH];
  logic [X_DUALWRITE:0][DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [X_DUALWRITE:0]                 mem_we_q   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             misalign_q;

  logic [X_DUALWRITE:0] we_s;
  logic                 mis;
  logic                 accept, push, pop, empty;
  logic [X_DUALWRITE:0] head_we;

  // x0 is never written; an odd rd cannot take the second word of a pair.
  generate
    if (X_DUALWRITE != 0) begin : g_dual
      always_comb begin
        we_s = x_result_we_i;
        mis  = 1'b0;
        if (x_result_rd_i == '0) we_s[0] = 1'b0;
        if (x_result_rd_i[0] && x_result_we_i[X_DUALWRITE]) begin
          we_s[X_DUALWRITE] = 1'b0;
          mis               = 1'b1;
        end
      end
    end else begin : g_single
      assign we_s = x_result_we_i & {N{x_result_rd_i != '0}};
      assign mis  = 1'b0;
    end
  endgenerate

  assign empty            = (count_q == '0);
  assign x_result_ready_o = (count_q != FULL);
  assign accept           = x_result_valid_i & x_result_ready_o;
  assign push             = accept & (|we_s);

  assign head_we   = empty ? '0 : mem_we_q[rd_ptr_q];
  assign we_b_o    = head_we & {N{~core_we_b_i}};
  assign pop       = |we_b_o;
  assign waddr_b_o = empty ? '0 : mem_rd_q[rd_ptr_q];
  assign wdata_b_o = empty ? '0 : mem_data_q[rd_ptr_q];

  assign empty_o        = empty;
  assign misalign_err_o = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
        mem_we_q[i]   <= '0;
      end
    end else begin
      misalign_q <= accept & mis;
      if (push) begin
        mem_rd_q[wr_ptr_q]   <= x_result_rd_i;
        mem_data_q[wr_ptr_q] <= x_result_data_i;
        mem_we_q[wr_ptr_q]   <= we_s;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

`ifdef CV32E40PX_XWB_HAZARD_EN
  logic [2:0][ADDR_WIDTH-1:0] raddr;
  logic [PTR_W-1:0]           hz_off;

  assign raddr = {raddr_c_i, raddr_b_i, raddr_a_i};

  // Entry i is live when its distance from the read pointer is below count.
  always_comb begin
    hazard_o = '0;
    hz_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_off = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, hz_off} < count_q) begin
        for (int k = 0; k < 3; k++) begin
          if (raddr[k] != '0) begin
            if (mem_we_q[i][0] && (mem_rd_q[i] == raddr[k])) hazard_o[k] = 1'b1;
            if ((X_DUALWRITE != 0) && mem_we_q[i][X_DUALWRITE] &&
                ((mem_rd_q[i] + ADDR_WIDTH'(1)) == raddr[k])) hazard_o[k] = 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule
